demux_quad1_4: RTL
==================

# demux_quad1_4

Registered 1-to-4 demultiplexer: the inverse of the quad 4-1 mux. A single valid/ready input stream of WIDTH-bit words, each tagged with a 2-bit select, is steered into one of four per-channel FIFOs. Each FIFO drives its own valid/ready output port. The block sits on the fan-out side of the datapath, opposite the quad mux, and feeds four independent consumers.

## Interface
- WIDTH, 4, data word width in bits (≥1).
- DEPTH, 2, entries per channel FIFO (power of two, ≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers in_data/in_sel this cycle.
- in_ready  out  1  block accepts the offered word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  2  destination channel: 0=A, 1=B, 2=C, 3=D.
- out_valid  out  4  bit k: channel k head entry valid.
- out_ready  in  4  bit k: consumer k takes the head this cycle.
- out_data  out  4*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
- out_count  out  4*($clog2(DEPTH)+1)  channel k occupancy, packed the same way.

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge. The word is written to FIFO[in_sel].
- in_ready = !full[in_sel]. It is combinational on in_sel and registered full flags only, and does not depend on in_valid.
- Output transfer on channel k occurs when out_valid[k] && out_ready[k] at a rising edge. FIFO[k] pops.
- out_valid[k] = (count[k] != 0). out_data[k] = head entry of FIFO[k] and is meaningful only while out_valid[k] is high.
- Per-channel order is strict FIFO. There is no ordering relation between channels.
- Push and pop on the same channel in the same edge:
  - Allowed when 0 < count < DEPTH. Count is unchanged and the pointers both advance.
  - When full: in_ready is low, so only the pop occurs. There is no same-cycle pass-through of freed space.
  - When empty: out_valid is low, so only the push occurs.
- A push on channel j and a pop on channel k (j≠k) in the same edge are independent.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count ranges over 0..DEPTH.
- in_sel and in_data while in_valid is low are ignored. An X on in_sel while in_valid is low must not corrupt state.
- Reset, asserted at any time including mid-transfer:
  - Counts and pointers go to 0. out_valid=4'b0000. out_count=0.
  - out_data=0, because storage is cleared.
  - in_ready reads 1 for any in_sel once rst deasserts.
  - A word presented during reset is not stored.

## Timing
- Latency: a word accepted at edge t appears with out_valid high in the cycle after edge t. Minimum in-to-out is 1 cycle; there is no combinational path from in_* to out_*.
- Throughput: 1 word/cycle into any non-full channel. Each channel sustains 1 word/cycle out.
- Comb paths:
  - in_sel → in_ready is the only path from an input to an output.
  - out_ready feeds state only, never outputs in the same cycle.
- The full flag and out_valid reflect state after the last edge. in_ready may therefore drop one cycle after the push that filled a channel.

## Structure
- Shared package: SEL_W=2, NUM_CH=4, channel index constants CH_A..CH_D, and a function for the packed-slice offset.
- One sub-module, demux_fifo2, instantiated 4×. It is parameterised by WIDTH and DEPTH and has ports clk, rst, push, din, pop, dout, count, full, empty.
- Top level contains only the select decode (push[k] = in_valid && in_ready && in_sel==k), the in_ready mux, and output packing.

## Test plan
- **Reset:** assert rst mid-stream with channel B holding 2 words → out_valid=0000, out_count=0, out_data=0, in_ready=1 for all sel after release.
- **Routing sweep:** for sel 0..3, send data 3,4,5,6 with all out_ready=1 → each word appears only on channel sel, one cycle later; Expected==Got for every case.
- **Full/backpressure:** out_ready[2]=0; send 0xA, 0xB, 0xC to sel=2 → first two accepted, count[2]=2, in_ready=0 for sel=2 but 1 for sel=0. Raise out_ready[2] → 0xA then 0xB popped in order.
- **Simultaneous push/pop:** channel D holds 1 word (7); push 9 and pop in the same edge → count stays 1, head becomes 9.
- **Wrap-around:** stream 10 words to sel=1 with out_ready[1] toggling 1,0,1,0… → all 10 words are output in order, and no count exceeds DEPTH.
- **Cross-channel concurrency:** push to A while popping C and D in the same edge → A count +1, C and D each −1, no other channel changes.

Source files
------------

// File: rtl/demux_quad1_4_pkg.sv
// Shared constants and helpers for the quad 1-to-4 demultiplexer.
// Channel indices and the packed-slice offset used for out_data/out_count.
package demux_quad1_4_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

  // Bit offset of channel ch inside a vector packed as NUM_CH fields of w bits.
  function automatic int unsigned slice_off(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux_quad1_4_if.sv
// Input stream plus four packed output streams of the quad demultiplexer.
// master = producer/consumers side, slave = demux side.
interface demux_quad1_4_if
  import demux_quad1_4_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH*CW-1:0]    out_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/demux_fifo2.sv
// Per-channel synchronous FIFO with occupancy count; storage clears on reset
// so the head word reads as zero after reset.
module demux_fifo2 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Guard locally as well, so a stray push/pop can never over/underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/demux_quad1_4.sv
// Registered 1-to-4 demultiplexer: steers a tagged input stream into one of
// four channel FIFOs, each with its own valid/ready output.
module demux_quad1_4
  import demux_quad1_4_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  demux_quad1_4_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] push, pop, full, empty;
  logic [WIDTH-1:0]  dout [NUM_CH];
  logic [CW-1:0]     cnt  [NUM_CH];

  // Only registered full flags feed in_ready; in_valid is deliberately excluded.
  assign bus.in_ready = ~full[bus.in_sel];

  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
    assign push[k] = bus.in_valid && bus.in_ready && (bus.in_sel == SEL_W'(k));
    assign pop[k]  = bus.out_ready[k] && !empty[k];

    demux_fifo2 #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .din   (bus.in_data),
      .pop   (pop[k]),
      .dout  (dout[k]),
      .count (cnt[k]),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign bus.out_valid[k]                           = !empty[k];
    assign bus.out_data[slice_off(k, WIDTH) +: WIDTH] = dout[k];
    assign bus.out_count[slice_off(k, CW) +: CW]      = cnt[k];
  end

endmodule
